// File: rtl/nv_nvdla_cdp_dp_cvtout_info_gen.sv
// -----------------------------------------------------------------------------
// nv_nvdla_cdp_dp_cvtout_info_gen
//
// Generates one info word per output element position of a CDP layer. The
// cube is walked width-first, then height, then 4-channel surface. Every word
// tells the convert-out stage which channel lanes carry data (lane mask) and
// where the word sits in the cube (last_w / last_h / last_c / layer_end and
// the surface index).
//
// Ports
//   nvdla_core_clk       clock, all state updates on the rising edge
//   nvdla_core_rst       synchronous active-high reset
//   op_en                single-cycle start pulse, honoured only in IDLE
//   reg2dp_width         cube width  - 1   (latched on op_en)
//   reg2dp_height        cube height - 1   (latched on op_en)
//   reg2dp_channel       channels    - 1   (latched on op_en)
//   data_info_in_vld_d2  info word valid
//   data_info_in_rdy_d2  downstream ready
//   data_info_in_pd_d2   info word:
//                          [3:0]  lane mask
//                          [4]    last_w
//                          [5]    last_h
//                          [6]    last_c
//                          [7]    layer_end
//                          [14:8] surface index s[6:0]
//   busy                 high while a layer is in progress (RUN)
//   op_done              one-cycle pulse, first IDLE cycle after layer_end
//
// Handshake: a word transfers in any cycle where vld=1 and rdy=1. vld and pd
// are pure functions of registered state, so once vld rises they hold until
// the transfer, and rdy never reaches vld combinationally.
// -----------------------------------------------------------------------------
module nv_nvdla_cdp_dp_cvtout_info_gen #(
  parameter int CNT_W = 13
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             op_en,
  input  logic [CNT_W-1:0] reg2dp_width,
  input  logic [CNT_W-1:0] reg2dp_height,
  input  logic [CNT_W-1:0] reg2dp_channel,
  output logic             data_info_in_vld_d2,
  input  logic             data_info_in_rdy_d2,
  output logic [14:0]      data_info_in_pd_d2,
  output logic             busy,
  output logic             op_done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_height;
  logic [CNT_W-1:0] cfg_channel;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] s_cnt;

  logic [CNT_W-1:0] s_last;
  logic             last_w;
  logic             last_h;
  logic             last_c;
  logic             layer_end;
  logic [3:0]       lane_mask;
  logic             xfer;
  logic             start;

  // Surface index of the final (possibly partial) 4-channel surface.
  assign s_last    = cfg_channel >> 2;
  assign last_w    = (w_cnt == cfg_width);
  assign last_h    = (h_cnt == cfg_height);
  assign last_c    = (s_cnt == s_last);
  assign layer_end = last_w & last_h & last_c;

  assign xfer  = data_info_in_vld_d2 & data_info_in_rdy_d2;
  assign start = (state == IDLE) & op_en;

  // Only the last surface can be partial; its active lanes follow the low two
  // bits of (channel - 1).
  always_comb begin
    lane_mask = 4'hF;
    if (last_c) begin
      case (cfg_channel[1:0])
        2'd0:    lane_mask = 4'h1;
        2'd1:    lane_mask = 4'h3;
        2'd2:    lane_mask = 4'h7;
        default: lane_mask = 4'hF;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state and state-derived outputs
  always_comb begin
    state_nxt           = state;
    data_info_in_vld_d2 = 1'b0;
    data_info_in_pd_d2  = 15'h0;
    busy                = 1'b0;
    case (state)
      IDLE: begin
        if (op_en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        data_info_in_vld_d2 = 1'b1;
        data_info_in_pd_d2  = {s_cnt[6:0], layer_end, last_c, last_h, last_w, lane_mask};
        busy                = 1'b1;
        if (xfer && layer_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Config latch and cube position counters. Counters move only on a
  // transfer, so a stalled word keeps its pd unchanged.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      cfg_width   <= '0;
      cfg_height  <= '0;
      cfg_channel <= '0;
      w_cnt       <= '0;
      h_cnt       <= '0;
      s_cnt       <= '0;
    end else if (start) begin
      cfg_width   <= reg2dp_width;
      cfg_height  <= reg2dp_height;
      cfg_channel <= reg2dp_channel;
      w_cnt       <= '0;
      h_cnt       <= '0;
      s_cnt       <= '0;
    end else if (xfer) begin
      if (last_w) begin
        w_cnt <= '0;
        if (last_h) begin
          h_cnt <= '0;
          // After layer_end all counters return to 0 for a clean idle state.
          if (last_c) begin
            s_cnt <= '0;
          end else begin
            s_cnt <= s_cnt + 1'b1;
          end
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end else begin
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

  // op_done lands in the first IDLE cycle after the layer_end transfer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      op_done <= 1'b0;
    end else begin
      op_done <= xfer & layer_end & (state == RUN);
    end
  end

endmodule
